// File: rtl/ex_pkg.sv
// Shared encodings for the Execute stage: multiply/divide opcodes, forwarding
// selects and the ALU control values used across the core.
package ex_pkg;

    // Multiply/divide operation carried down the pipe with each instruction.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    // Forwarding selects; 2'b11 falls back to the register file.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // ALU control encodings.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    // MULT/MULTU/DIV/DIVU: operations that launch the iterative unit.
    function automatic logic mdIsStart(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    // Any operation that depends on the unit (launch or HI/LO read).
    function automatic logic mdIsOp(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_MFLO);
    endfunction

    function automatic logic mdIsDiv(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic mdIsSigned(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO pair.
// Operands are taken as magnitudes; signs are reapplied when the result commits.
module md_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mdOp,
    input  logic             stall,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    logic               start;
    logic               isDivOp;
    logic               negA;
    logic               negB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;

    logic               busyQ;
    logic [CNT_W-1:0]   cntQ;
    logic [2*WIDTH-1:0] accQ;
    logic [2*WIDTH-1:0] accD;
    logic [WIDTH-1:0]   opBQ;
    logic               isDivQ;
    logic               negLoQ;
    logic               negHiQ;
    logic               divZeroQ;
    logic [WIDTH-1:0]   hiQ;
    logic [WIDTH-1:0]   loQ;
    logic [WIDTH-1:0]   hiD;
    logic [WIDTH-1:0]   loD;

    logic [WIDTH:0]     remSh;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               lastStep;

    // Launch decode and operand magnitudes.
    always_comb begin
        start   = mdIsStart(mdOp) && !busyQ && !stall;
        isDivOp = mdIsDiv(mdOp);
        negA    = mdIsSigned(mdOp) && srcA[WIDTH-1];
        negB    = mdIsSigned(mdOp) && srcB[WIDTH-1];
        absA    = negA ? -srcA : srcA;
        absB    = negB ? -srcB : srcB;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        accD  = accQ;
        remSh = '0;
        diff  = '0;
        sum   = '0;
        if (isDivQ) begin
            // Partial remainder is below the divisor, so the shifted value fits WIDTH+1 bits.
            remSh = accQ[2*WIDTH-1:WIDTH-1];
            diff  = remSh - {1'b0, opBQ};
            if (!diff[WIDTH]) begin
                accD = {diff[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};
            end else begin
                accD = {remSh[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, opBQ} : '0);
            accD = {sum, accQ[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final step's result; divide by zero forces an all-ones quotient.
    always_comb begin
        lastStep = busyQ && (cntQ == CNT_W'(1));
        prod     = negLoQ ? -accD : accD;
        quo      = accD[WIDTH-1:0];
        rem      = accD[2*WIDTH-1:WIDTH];
        if (isDivQ) begin
            hiD = negHiQ ? -rem : rem;
            loD = divZeroQ ? '1 : (negLoQ ? -quo : quo);
        end else begin
            hiD = prod[2*WIDTH-1:WIDTH];
            loD = prod[WIDTH-1:0];
        end
    end

    // Launch, iterate and retire the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ    <= 1'b0;
            cntQ     <= '0;
            accQ     <= '0;
            opBQ     <= '0;
            isDivQ   <= 1'b0;
            negLoQ   <= 1'b0;
            negHiQ   <= 1'b0;
            divZeroQ <= 1'b0;
        end else if (start) begin
            busyQ    <= 1'b1;
            cntQ     <= CNT_W'(WIDTH);
            accQ     <= {{WIDTH{1'b0}}, (isDivOp ? absA : absB)};
            opBQ     <= isDivOp ? absB : absA;
            isDivQ   <= isDivOp;
            negLoQ   <= negA ^ negB;
            negHiQ   <= negA;
            divZeroQ <= (srcB == '0);
        end else if (busyQ) begin
            accQ <= accD;
            cntQ <= cntQ - CNT_W'(1);
            if (lastStep) begin
                busyQ <= 1'b0;
            end
        end
    end

    // HI/LO only move on the final step of an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiQ <= '0;
            loQ <= '0;
        end else if (lastStep) begin
            hiQ <= hiD;
            loQ <= loD;
        end
    end

    assign hi   = hiQ;
    assign lo   = loQ;
    assign busy = busyQ;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, immediate and destination select, single-cycle
// ALU, and the iterative multiply/divide unit with its stall request.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ALUControlE,
    input  logic [2:0]        MdOpE,
    input  logic              ALUSrcE,
    input  logic              RegDstE,
    input  logic              StallE,
    input  logic [WIDTH-1:0]  RD1E,
    input  logic [WIDTH-1:0]  RD2E,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [WIDTH-1:0]  ResultW,
    input  logic [WIDTH-1:0]  ALUOutM,
    input  logic [WIDTH-1:0]  SignImmE,
    output logic [WIDTH-1:0]  ALUOutE,
    output logic [WIDTH-1:0]  WriteDataE,
    output logic [REG_AW-1:0] WriteRegE,
    output logic              MdStallE,
    output logic              MdBusy
);

    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] aluResult;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    function automatic logic [WIDTH-1:0] fwd(input logic [WIDTH-1:0] rf,
                                             input logic [WIDTH-1:0] resW,
                                             input logic [WIDTH-1:0] aluM,
                                             input logic [1:0]       sel);
        case (sel)
            FWD_W:   return resW;
            FWD_M:   return aluM;
            default: return rf;
        endcase
    endfunction

    // Forwarding muxes and immediate select.
    always_comb begin
        srcA      = fwd(RD1E, ResultW, ALUOutM, ForwardAE);
        writeData = fwd(RD2E, ResultW, ALUOutM, ForwardBE);
        srcB      = ALUSrcE ? SignImmE : writeData;
    end

    // Single-cycle ALU.
    always_comb begin
        case (ALUControlE)
            ALU_AND:  aluResult = srcA & srcB;
            ALU_OR:   aluResult = srcA | srcB;
            ALU_ADD:  aluResult = srcA + srcB;
            ALU_XOR:  aluResult = srcA ^ srcB;
            ALU_NOR:  aluResult = ~(srcA | srcB);
            ALU_SLTU: aluResult = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            ALU_SUB:  aluResult = srcA - srcB;
            ALU_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            default:  aluResult = '0;
        endcase
    end

    // Result and destination selection.
    always_comb begin
        case (MdOpE)
            MD_MFHI: ALUOutE = hi;
            MD_MFLO: ALUOutE = lo;
            default: ALUOutE = aluResult;
        endcase
        WriteDataE = writeData;
        WriteRegE  = RegDstE ? RdE : RtE;
    end

    // The unit captures the forwarded B operand, never the immediate.
    md_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) uMd (
        .clk   (clk),
        .rst_n (rst_n),
        .mdOp  (MdOpE),
        .stall (StallE),
        .srcA  (srcA),
        .srcB  (writeData),
        .hi    (hi),
        .lo    (lo),
        .busy  (MdBusy)
    );

    // The issuing op sees MdBusy low, so it never stalls itself.
    assign MdStallE = MdBusy && mdIsOp(MdOpE);

endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: a driver issues instructions and pushes the
// expected Execute outputs; a monitor pops and compares as each one leaves E.
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic [3:0]    ALUControlE;
    logic [2:0]    MdOpE;
    logic          ALUSrcE;
    logic          RegDstE;
    logic          StallE;
    logic [W-1:0]  RD1E;
    logic [W-1:0]  RD2E;
    logic [AW-1:0] RtE;
    logic [AW-1:0] RdE;
    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic [W-1:0]  ResultW;
    logic [W-1:0]  ALUOutM;
    logic [W-1:0]  SignImmE;
    logic [W-1:0]  ALUOutE;
    logic [W-1:0]  WriteDataE;
    logic [AW-1:0] WriteRegE;
    logic          MdStallE;
    logic          MdBusy;

    typedef struct {
        logic [3:0]    ctl;
        logic [2:0]    md;
        logic          aluSrc;
        logic          regDst;
        logic [W-1:0]  rd1;
        logic [W-1:0]  rd2;
        logic [W-1:0]  resW;
        logic [W-1:0]  aluM;
        logic [W-1:0]  imm;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [1:0]    fa;
        logic [1:0]    fb;
        int            hold;
    } inst_t;

    typedef struct {
        logic [W-1:0]  aluOut;
        logic [W-1:0]  wdata;
        logic [AW-1:0] wreg;
        logic          mdOp;
        string         name;
    } exp_t;

    exp_t         sbQ[$];
    exp_t         monE;
    int           checks    = 0;
    int           failures  = 0;
    int           busyRun   = 0;
    logic         instValid = 1'b0;
    logic [W-1:0] mHi       = '0;
    logic [W-1:0] mLo       = '0;

    ex_stage_md dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ALUControlE (ALUControlE),
        .MdOpE       (MdOpE),
        .ALUSrcE     (ALUSrcE),
        .RegDstE     (RegDstE),
        .StallE      (StallE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .RtE         (RtE),
        .RdE         (RdE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .ALUOutM     (ALUOutM),
        .SignImmE    (SignImmE),
        .ALUOutE     (ALUOutE),
        .WriteDataE  (WriteDataE),
        .WriteRegE   (WriteRegE),
        .MdStallE    (MdStallE),
        .MdBusy      (MdBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] mFwd(input logic [W-1:0] rf, input logic [W-1:0] w,
                                          input logic [W-1:0] m, input logic [1:0] sel);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rf;
    endfunction

    function automatic logic [W-1:0] mAlu(input logic [3:0] ctl, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (ctl)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // Architectural HI/LO effect of a MULT/DIV in program order.
    task automatic mdModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sp;
        logic [63:0]  up;
        int           sa;
        int           sb;
        case (op)
            MD_MULT: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                mHi = sp[63:32];
                mLo = sp[31:0];
            end
            MD_MULTU: begin
                up  = {32'd0, a} * {32'd0, b};
                mHi = up[63:32];
                mLo = up[31:0];
            end
            MD_DIV: begin
                if (b == 0) begin
                    mLo = '1;
                    mHi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mLo = a;
                    mHi = '0;
                end else begin
                    sa  = a;
                    sb  = b;
                    mLo = sa / sb;
                    mHi = sa % sb;
                end
            end
            MD_DIVU: begin
                if (b == 0) begin
                    mLo = '1;
                    mHi = a;
                end else begin
                    mLo = a / b;
                    mHi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] rndVal();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic inst_t mkRand();
        inst_t i;
        i.ctl    = 4'($urandom_range(0, 8));
        i.md     = 3'($urandom_range(0, 7));
        i.aluSrc = 1'($urandom);
        i.regDst = 1'($urandom);
        i.rd1    = rndVal();
        i.rd2    = rndVal();
        i.resW   = rndVal();
        i.aluM   = rndVal();
        i.imm    = rndVal();
        i.rt     = 5'($urandom);
        i.rd     = 5'($urandom);
        i.fa     = 2'($urandom);
        i.fb     = 2'($urandom);
        i.hold   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        return i;
    endfunction

    function automatic inst_t mkMd(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        inst_t i;
        i        = mkRand();
        i.md     = op;
        i.rd1    = a;
        i.rd2    = b;
        i.fa     = FWD_RF;
        i.fb     = FWD_RF;
        i.aluSrc = 1'b0;
        i.hold   = 0;
        return i;
    endfunction

    task automatic bubble(input int n);
        instValid = 1'b0;
        MdOpE     = MD_NONE;
        StallE    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction, push its expectation, hold it until it leaves E.
    task automatic issue(input inst_t i, input string name, output int stallCnt);
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] wd;
        logic [W-1:0] b;
        logic         lastBusy;
        logic         heldPrev;
        logic         adv;
        int           cyc;
        ALUControlE = i.ctl;
        MdOpE       = i.md;
        ALUSrcE     = i.aluSrc;
        RegDstE     = i.regDst;
        RD1E        = i.rd1;
        RD2E        = i.rd2;
        ResultW     = i.resW;
        ALUOutM     = i.aluM;
        SignImmE    = i.imm;
        RtE         = i.rt;
        RdE         = i.rd;
        ForwardAE   = i.fa;
        ForwardBE   = i.fb;
        instValid   = 1'b1;
        a  = mFwd(i.rd1, i.resW, i.aluM, i.fa);
        wd = mFwd(i.rd2, i.resW, i.aluM, i.fb);
        b  = i.aluSrc ? i.imm : wd;
        if (i.md == MD_MFHI)      e.aluOut = mHi;
        else if (i.md == MD_MFLO) e.aluOut = mLo;
        else                      e.aluOut = mAlu(i.ctl, a, b);
        e.wdata = wd;
        e.wreg  = i.regDst ? i.rd : i.rt;
        e.mdOp  = (i.md >= MD_MULT) && (i.md <= MD_MFLO);
        e.name  = name;
        sbQ.push_back(e);
        if (i.md >= MD_MULT && i.md <= MD_DIVU) mdModel(i.md, a, wd);
        stallCnt = 0;
        cyc      = 0;
        adv      = 1'b0;
        heldPrev = 1'b0;
        lastBusy = MdBusy;
        while (!adv) begin
            StallE = (cyc < i.hold);
            @(negedge clk);
            // An externally held edge must not launch anything.
            if (heldPrev && !lastBusy) chk({name, "_held_nostart"}, 64'(MdBusy), 64'd0);
            heldPrev = StallE;
            lastBusy = MdBusy;
            if (MdStallE) stallCnt++;
            adv = !MdStallE && !StallE;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 400) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout actual=%0d cycles required=<400", name, cyc);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "instruction never left E");
            end
        end
        instValid = 1'b0;
        MdOpE     = MD_NONE;
        StallE    = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && instValid && !MdStallE && !StallE) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
                monE = sbQ.pop_front();
                chk({monE.name, "_aluOut"}, 64'(ALUOutE), 64'(monE.aluOut));
                chk({monE.name, "_writeData"}, 64'(WriteDataE), 64'(monE.wdata));
                chk({monE.name, "_writeReg"}, 64'(WriteRegE), 64'(monE.wreg));
                if (monE.mdOp) chk({monE.name, "_busy_at_issue"}, 64'(MdBusy), 64'd0);
            end
        end
    end

    // Every uninterrupted busy run lasts exactly W cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun = 0;
        end else if (MdBusy) begin
            busyRun++;
        end else if (busyRun > 0) begin
            chk("busy_length", 64'(busyRun), 64'(W));
            busyRun = 0;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        inst_t i;
        int    st;
        rst_n       = 1'b0;
        StallE      = 1'b0;
        ALUControlE = ALU_ADD;
        MdOpE       = MD_MFHI;
        ALUSrcE     = 1'b0;
        RegDstE     = 1'b0;
        RD1E        = '0;
        RD2E        = '0;
        RtE         = '0;
        RdE         = '0;
        ForwardAE   = FWD_RF;
        ForwardBE   = FWD_RF;
        ResultW     = '0;
        ALUOutM     = '0;
        SignImmE    = '0;
        #12;
        chk("reset_busy", 64'(MdBusy), 64'd0);
        chk("reset_stall", 64'(MdStallE), 64'd0);
        chk("reset_hi_read", 64'(ALUOutE), 64'd0);
        #10;
        rst_n = 1'b1;
        MdOpE = MD_NONE;
        @(posedge clk);
        #1;

        // Forwarding from M into A, register B, RegDst selecting Rd.
        i        = mkMd(MD_NONE, 32'd5, 32'd3);
        i.ctl    = ALU_ADD;
        i.aluM   = 32'd9;
        i.fa     = FWD_M;
        i.regDst = 1'b1;
        i.rd     = 5'd7;
        issue(i, "fwd_add", st);

        // Signed multiply, then MFLO one cycle into the operation.
        issue(mkMd(MD_MULT, 32'hFFFF_FFFD, 32'd7), "mult_neg", st);
        bubble(1);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_mult", st);
        chk("stall_mflo_cycles", 64'(st), 64'd31);
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_mult", st);
        chk("stall_mfhi_idle", 64'(st), 64'd0);

        // Divide corner cases.
        issue(mkMd(MD_DIV, 32'hFFFF_FFF9, 32'd2), "div_neg", st);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_div", st);
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_div", st);
        issue(mkMd(MD_DIVU, 32'd7, 32'd0), "divu_zero", st);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_divz", st);
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_divz", st);
        issue(mkMd(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF), "div_ovf", st);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_ovf", st);
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_ovf", st);

        // Back-to-back multiplies: the second waits for the first to finish.
        issue(mkMd(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0), "mult_first", st);
        issue(mkMd(MD_MULT, 32'h8000_0000, 32'h8000_0000), "mult_second", st);
        chk("stall_second_mult", 64'(st), 64'd32);
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_second", st);

        // Immediate on B must not reach the unit.
        i        = mkMd(MD_MULTU, 32'd11, 32'd13);
        i.aluSrc = 1'b1;
        i.imm    = 32'd1000;
        issue(i, "mult_imm", st);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_imm", st);

        // External stall holds a multiply for three cycles.
        i      = mkMd(MD_MULT, 32'hFFFF_FF00, 32'd300);
        i.hold = 3;
        issue(i, "mult_held", st);
        chk("stall_held_self", 64'(st), 64'd0);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_held", st);

        // Asynchronous reset in the middle of an operation.
        issue(mkMd(MD_MULTU, 32'hDEAD_BEEF, 32'hCAFE_F00D), "mult_reset", st);
        MdOpE = MD_MFHI;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(MdBusy), 64'd0);
        chk("midreset_stall", 64'(MdStallE), 64'd0);
        chk("midreset_hi", 64'(dut.uMd.hiQ), 64'd0);
        chk("midreset_lo", 64'(dut.uMd.loQ), 64'd0);
        mHi = '0;
        mLo = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        MdOpE = MD_NONE;
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_after_reset", st);
        issue(mkMd(MD_DIVU, 32'd100, 32'd7), "divu_after_reset", st);
        issue(mkMd(MD_MFLO, '0, '0), "mflo_after_reset", st);
        issue(mkMd(MD_MFHI, '0, '0), "mfhi_after_reset2", st);

        // Randomised instruction stream.
        for (int n = 0; n < 80; n++) begin
            issue(mkRand(), $sformatf("rnd%0d", n), st);
            if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 3));
        end

        bubble(40);
        chk("sb_empty", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised Execute stage for the pipelined MIPS core.
- Contains operand forwarding, immediate select, destination-register select and the single-cycle ALU.
- Adds an iterative multiply/divide unit with architectural HI/LO registers.
- Raises a stall request to the hazard unit while a MFHI/MFLO or a second MULT/DIV must wait for an operation in flight.

Parameters:
- WIDTH, 32, datapath width in bits; must be even and >= 8.
- REG_AW, 5, register-file address width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- ALUControlE  in  4  ALU operation; encoding shared with the existing ALU.
- MdOpE  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO; 7 is treated as NONE.
- ALUSrcE  in  1  selects the B operand: 1 = SignImmE, 0 = forwarded RD2.
- RegDstE  in  1  selects the destination: 1 = RdE, 0 = RtE.
- StallE  in  1  E stage held this cycle by a hazard source other than MdStallE.
- RD1E, RD2E  in  WIDTH  register-file read data.
- RtE, RdE  in  REG_AW  register specifiers.
- ForwardAE, ForwardBE  in  2  forwarding select: 00 = RDx, 01 = ResultW, 10 = ALUOutM, 11 = RDx.
- ResultW, ALUOutM  in  WIDTH  forwarding sources.
- SignImmE  in  WIDTH  sign-extended immediate.
- ALUOutE  out  WIDTH  ALU result, or HI/LO for MFHI/MFLO.
- WriteDataE  out  WIDTH  forwarded B operand before the immediate mux.
- WriteRegE  out  REG_AW  destination register.
- MdStallE  out  1  stall request to the hazard unit; the hazard unit freezes F/D/E and bubbles M.
- MdBusy  out  1  multiply/divide unit iterating.

Behaviour:
- Datapath is combinational: SrcA = fwd(RD1E, ForwardAE); WriteDataE = fwd(RD2E, ForwardBE); SrcB = ALUSrcE ? SignImmE : WriteDataE.
- ALUOutE = HI when MdOpE = MFHI, LO when MdOpE = MFLO, otherwise ALU(SrcA, SrcB).
- Start condition: MdOpE is in {1..4}, MdBusy = 0 and StallE = 0.
  - On the start edge, capture SrcA and WriteDataE (never the immediate).
  - For signed ops, capture absolute values and record the result signs.
  - Load the counter with WIDTH and set MdBusy.
- Iteration: one radix-2 step per cycle while busy.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each step. The step taken with the counter at 1 commits HI/LO (sign-corrected) and clears MdBusy on the same edge.
  - MdBusy is therefore high for exactly WIDTH cycles. HI/LO are readable in the first cycle MdBusy is 0.
- Results:
  - Multiply: HI = product upper half, LO = product lower half.
  - Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend; the quotient truncates toward zero.
  - Divide by zero: LO = all ones, HI = dividend. The operation takes the normal WIDTH cycles.
  - Signed MIN / -1: LO = MIN, HI = 0.
- MdStallE = MdBusy AND MdOpE in {1..6}, combinational.
  - MdStallE is never asserted when MdBusy = 0.
  - The issuing MULT/DIV itself does not stall.
- StallE = 1 with a MULT/DIV in E: no start. The op starts on the first cycle it is present with StallE = 0. Each instruction starts exactly once because the hazard unit advances E on that edge.
- Reset (async assert, any time including mid-operation):
  - MdBusy = 0, counter = 0, HI = 0, LO = 0, accumulators = 0.
  - MdStallE = 0. The combinational outputs follow their inputs.
- HI/LO change only on a commit edge or reset.

Decomposition:
- Shared package ex_pkg holds:
  - MdOpE encodings (MD_NONE..MD_MFLO);
  - forwarding select constants (FWD_RF, FWD_W, FWD_M);
  - the ALUControl encodings already used by the core.
- One sub-module, md_unit, owns the counter, accumulators, sign fix-up, HI/LO and MdBusy. The forwarding/ALU/mux logic stays in ex_stage_md.

Test Plan:
- Forwarding, no MD op: RD1E = 5, ALUOutM = 9, ForwardAE = 10, RD2E = 3, ALU add, ALUSrcE = 0 -> ALUOutE = 12 and WriteDataE = 3. With RegDstE = 1, RdE = 7 -> WriteRegE = 7.
- Signed multiply:
  - MULT with SrcA = -3 (0xFFFFFFFD), B = 7 -> MdBusy = 1 for exactly 32 cycles.
  - Then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFEB (-21).
- Signed divide:
  - DIV -7 / 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
  - DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
  - DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- Stall handshake:
  - MFLO presented 1 cycle after MULT start -> MdStallE = 1 for 31 cycles, then 0; ALUOutE equals the new LO.
  - A second MULT during busy -> stalled, then starts the cycle after MdBusy falls.
- External stall: MULT held with StallE = 1 for 3 cycles -> MdBusy stays 0, then exactly one start when StallE falls.
- Reset mid-op: rst_n low at iteration 10 -> MdBusy, HI and LO are 0 immediately (asynchronously). After release, MFHI reads 0 and a new DIVU 100 / 7 gives LO = 14, HI = 2.
